// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: requester id and the
// read tag that travels alongside each in-flight memory read.
package mem_arbiter_pkg;

   localparam int NUM_REQ = 2;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
      logic    err;
   } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_tag_pipe.sv
// Fixed-depth shift register of read tags; the tag leaving the last stage
// lines up with the memory read data of the operation that launched it.
module mem_arbiter_tag_pipe
   import mem_arbiter_pkg::*;
#(
   parameter int RD_LATENCY = 3
) (
   input  logic    clk,
   input  logic    clr,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t stage_q [RD_LATENCY];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < RD_LATENCY; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= tag_in;
         for (int i = 1; i < RD_LATENCY; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tag_out = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer for a single-port-pair memory.
// Optional out-of-range address checking: define MEM_ARBITER_ADDR_CHECK_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int MEM_DEPTH  = 3,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int RD_LATENCY = 3
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0]                   req_we,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]                   rsp_valid,
   output logic [DATA_WIDTH-1:0]                rsp_data,
   output logic                                 rsp_err,
   output logic                                 mem_wr_en,
   output logic [ADDR_WIDTH-1:0]                mem_wr_addr,
   output logic [DATA_WIDTH-1:0]                mem_wr_data,
   output logic                                 mem_rd_en,
   output logic [ADDR_WIDTH-1:0]                mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]                mem_rd_data
);

   req_id_t                 prio;
   logic                    grant_p0;
   req_id_t                 grant_id_p0;
   logic                    sel_we_p0;
   logic [ADDR_WIDTH-1:0]   sel_addr_p0;
   logic [DATA_WIDTH-1:0]   sel_wdata_p0;
   logic                    addr_err_p0;
   rd_tag_t                 tag_p1;
   rd_tag_t                 tag_exit;

   // Stage p0: combinational grant, one-hot ready, selected request fields
   always_comb begin
      req_ready   = '0;
      grant_p0    = 1'b0;
      grant_id_p0 = prio;
      if (!reset) begin
         if (req_valid == 2'b11) begin
            grant_p0    = 1'b1;
            grant_id_p0 = prio;
         end else if (req_valid[0]) begin
            grant_p0    = 1'b1;
            grant_id_p0 = 1'b0;
         end else if (req_valid[1]) begin
            grant_p0    = 1'b1;
            grant_id_p0 = 1'b1;
         end
         if (grant_p0) req_ready[grant_id_p0] = 1'b1;
      end
   end

   assign sel_we_p0    = req_we[grant_id_p0];
   assign sel_addr_p0  = req_addr[grant_id_p0];
   assign sel_wdata_p0 = req_wdata[grant_id_p0];

`ifdef MEM_ARBITER_ADDR_CHECK_EN
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
   assign addr_err_p0 = ({1'b0, sel_addr_p0} >= DEPTH_LIM);
`else
   assign addr_err_p0 = 1'b0;
`endif

   // Stage p1: registered memory command and the tag launched with it.
   // Erroring requests of either kind skip the memory but still return a tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio        <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         mem_rd_addr <= '0;
         tag_p1      <= '0;
      end else begin
         mem_wr_en    <= grant_p0 && sel_we_p0 && !addr_err_p0;
         mem_rd_en    <= grant_p0 && !sel_we_p0 && !addr_err_p0;
         tag_p1.valid <= grant_p0 && (!sel_we_p0 || addr_err_p0);
         tag_p1.id    <= grant_id_p0;
         tag_p1.err   <= grant_p0 && addr_err_p0;
         if (grant_p0) prio <= ~grant_id_p0;
         if (grant_p0 && sel_we_p0 && !addr_err_p0) begin
            mem_wr_addr <= sel_addr_p0;
            mem_wr_data <= sel_wdata_p0;
         end
         if (grant_p0 && !sel_we_p0 && !addr_err_p0) mem_rd_addr <= sel_addr_p0;
      end
   end

   mem_arbiter_tag_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) u_tag_pipe (
      .clk     (clk),
      .clr     (reset),
      .tag_in  (tag_p1),
      .tag_out (tag_exit)
   );

   // Stage p2: tag exits together with memory data; route strobe by id
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= '0;
         rsp_err   <= 1'b0;
         if (tag_exit.valid) begin
            rsp_valid[tag_exit.id] <= 1'b1;
            rsp_err                <= tag_exit.err;
            rsp_data               <= tag_exit.err ? '0 : mem_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory and a
// per-cycle expectation ring derived from accepted requests.
module tb_mem_arbiter;

   localparam int DW    = 4;
   localparam int DEPTH = 3;
   localparam int AW    = $clog2(DEPTH);
   localparam int RDL   = 3;
   localparam int RING  = 64;
   localparam int NWORD = 1 << AW;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [1:0]           req_we;
   logic [1:0][AW-1:0]   req_addr;
   logic [1:0][DW-1:0]   req_wdata;
   logic [1:0]           rsp_valid;
   logic [DW-1:0]        rsp_data;
   logic                 rsp_err;
   logic                 mem_wr_en;
   logic [AW-1:0]        mem_wr_addr;
   logic [DW-1:0]        mem_wr_data;
   logic                 mem_rd_en;
   logic [AW-1:0]        mem_rd_addr;
   logic [DW-1:0]        mem_rd_data;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   mem_arbiter #(
      .DATA_WIDTH (DW),
      .MEM_DEPTH  (DEPTH),
      .RD_LATENCY (RDL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data)
   );

   always #5 clk = ~clk;

   // Behavioural memory: write on the edge, read data after RDL edges
   logic [DW-1:0] mem_arr [NWORD];
   logic [DW-1:0] rd_pipe [RDL];
   assign mem_rd_data = rd_pipe[RDL-1];

   always @(posedge clk) begin
      if (mem_wr_en) mem_arr[mem_wr_addr] <= mem_wr_data;
      rd_pipe[0] <= mem_rd_en ? mem_arr[mem_rd_addr] : '0;
      for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   // Reference model state
   logic [DW-1:0] shadow [NWORD];
   int            prio;
   logic          r_wr_en   [RING];
   logic [AW-1:0] r_wr_addr [RING];
   logic [DW-1:0] r_wr_data [RING];
   logic          r_rd_en   [RING];
   logic [AW-1:0] r_rd_addr [RING];
   logic [1:0]    r_rsp_v   [RING];
   logic [DW-1:0] r_rsp_d   [RING];
   logic          r_rsp_e   [RING];
   logic [AW-1:0] h_wr_addr, h_rd_addr;
   logic [DW-1:0] h_wr_data, h_rsp_data;

   task automatic clear_model();
      for (int i = 0; i < RING; i++) begin
         r_wr_en[i] = 1'b0; r_wr_addr[i] = '0; r_wr_data[i] = '0;
         r_rd_en[i] = 1'b0; r_rd_addr[i] = '0;
         r_rsp_v[i] = '0;   r_rsp_d[i] = '0;   r_rsp_e[i] = 1'b0;
      end
      h_wr_addr = '0; h_rd_addr = '0; h_wr_data = '0; h_rsp_data = '0;
      prio = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: check registered outputs, drive inputs, check grant
   task automatic step(input logic rst_i, input logic [1:0] v, input logic [1:0] we,
                       input logic [1:0][AW-1:0] a, input logic [1:0][DW-1:0] d);
      int   s, g, t;
      logic oob;
      @(negedge clk);
      s = cyc % RING;
      if (r_wr_en[s]) begin h_wr_addr = r_wr_addr[s]; h_wr_data = r_wr_data[s]; end
      if (r_rd_en[s]) h_rd_addr = r_rd_addr[s];
      if (r_rsp_v[s] != 2'b00) h_rsp_data = r_rsp_d[s];
      check("mem_wr_en",   32'(mem_wr_en),   32'(r_wr_en[s]));
      check("mem_wr_addr", 32'(mem_wr_addr), 32'(h_wr_addr));
      check("mem_wr_data", 32'(mem_wr_data), 32'(h_wr_data));
      check("mem_rd_en",   32'(mem_rd_en),   32'(r_rd_en[s]));
      check("mem_rd_addr", 32'(mem_rd_addr), 32'(h_rd_addr));
      check("rsp_valid",   32'(rsp_valid),   32'(r_rsp_v[s]));
      check("rsp_data",    32'(rsp_data),    32'(h_rsp_data));
      check("rsp_err",     32'(rsp_err),     32'(r_rsp_e[s]));
      r_wr_en[s] = 1'b0; r_rd_en[s] = 1'b0; r_rsp_v[s] = '0; r_rsp_e[s] = 1'b0;

      reset = rst_i; req_valid = v; req_we = we; req_addr = a; req_wdata = d;
      #1;
      if (rst_i)           g = -1;
      else if (v == 2'b11) g = prio;
      else if (v[0])       g = 0;
      else if (v[1])       g = 1;
      else                 g = -1;
      check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));

      if (rst_i) begin
         clear_model();
      end else if (g >= 0) begin
         prio = 1 - g;
`ifdef MEM_ARBITER_ADDR_CHECK_EN
         oob = (int'(a[g]) >= DEPTH);
`else
         oob = 1'b0;
`endif
         t = (cyc + RDL + 2) % RING;
         if (oob) begin
            r_rsp_v[t] = 2'b01 << g; r_rsp_d[t] = '0; r_rsp_e[t] = 1'b1;
         end else if (we[g]) begin
            r_wr_en[(cyc+1)%RING] = 1'b1;
            r_wr_addr[(cyc+1)%RING] = a[g];
            r_wr_data[(cyc+1)%RING] = d[g];
            shadow[a[g]] = d[g];
         end else begin
            r_rd_en[(cyc+1)%RING] = 1'b1;
            r_rd_addr[(cyc+1)%RING] = a[g];
            r_rsp_v[t] = 2'b01 << g; r_rsp_d[t] = shadow[a[g]]; r_rsp_e[t] = 1'b0;
         end
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, '0, '0);
   endtask

   initial begin
      for (int i = 0; i < NWORD; i++) begin mem_arr[i] = '0; shadow[i] = '0; end
      for (int i = 0; i < RDL; i++) rd_pipe[i] = '0;
      clear_model();
      reset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);

      // Reset held with requests present: nothing accepted, outputs zero
      step(1'b1, 2'b11, 2'b00, {2'd1, 2'd0}, '0);
      step(1'b1, 2'b11, 2'b11, {2'd1, 2'd0}, {4'd3, 4'd5});

      // Requester 0 writes 1 to address 0, then reads it back
      step(1'b0, 2'b01, 2'b01, {2'd0, 2'd0}, {4'd0, 4'd1});
      step(1'b0, 2'b01, 2'b00, {2'd0, 2'd0}, '0);
      idle(RDL + 3);

      // Both requesters continuously reading: grants alternate from 0
      step(1'b1, 2'b00, 2'b00, '0, '0);
      for (int i = 0; i < 8; i++)
         step(1'b0, 2'b11, 2'b00, {AW'(i % 3), AW'((i + 1) % 3)}, '0);
      idle(RDL + 3);

      // prio=1: requester 1 writes 2 to addr 1 first, requester 0 reads it next
      step(1'b0, 2'b01, 2'b00, {2'd0, 2'd2}, '0);
      step(1'b0, 2'b11, 2'b10, {2'd1, 2'd1}, {4'd2, 4'd0});
      step(1'b0, 2'b01, 2'b00, {2'd1, 2'd1}, '0);
      idle(RDL + 3);

      // Read in flight, reset two cycles later: response discarded
      step(1'b0, 2'b10, 2'b00, {2'd2, 2'd0}, '0);
      idle(1);
      step(1'b1, 2'b11, 2'b11, {2'd2, 2'd2}, {4'd7, 4'd7});
      idle(RDL + 4);

      // Out-of-range address 3: read, then write, from requester 1
      step(1'b0, 2'b10, 2'b00, {2'd3, 2'd0}, '0);
      step(1'b0, 2'b10, 2'b10, {2'd3, 2'd0}, {4'd9, 4'd0});
      step(1'b0, 2'b10, 2'b00, {2'd3, 2'd0}, '0);
      idle(RDL + 3);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0),
              2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)),
              {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))},
              {DW'($urandom), DW'($urandom)});
      end
      idle(RDL + 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
